// File: rtl/tl_pkg.sv
// tl_pkg: phase encodings, light codes and light decode shared by the phase scheduler.
package tl_pkg;
   localparam logic [2:0] A_GRN = 3'd0, A_YEL = 3'd1, A_LFT = 3'd2, A_LYEL = 3'd3;
   localparam logic [2:0] B_GRN = 3'd4, B_YEL = 3'd5, B_LFT = 3'd6, B_LYEL = 3'd7;
   localparam logic [1:0] L_GREEN = 2'b00, L_YELLOW = 2'b01, L_LEFT = 2'b10, L_RED = 2'b11;

   // Returns {La, Lb}; bit 2 selects the road that owns the phase, the other road is red.
   function automatic logic [3:0] lights(input logic [2:0] s);
      logic [1:0] l;
      l = (s[1:0] == 2'd0) ? L_GREEN : (s[1:0] == 2'd2) ? L_LEFT : L_YELLOW;
      return s[2] ? {L_RED, l} : {l, L_RED};
   endfunction
endpackage

// File: rtl/tl_phase_timer.sv
// tl_phase_timer: per-phase cycle counter with synchronous clear and saturation.
module tl_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;
endmodule

// File: rtl/tl_phase_scheduler.sv
// tl_phase_scheduler: eight-phase two-road intersection sequencer with min/max green,
// fixed yellow/left durations and latched protected-left requests.
module tl_phase_scheduler
   import tl_pkg::*;
#(
   parameter int CNT_W     = 8,
   parameter int GREEN_MIN = 10,
   parameter int GREEN_MAX = 40,
   parameter int YELLOW_T  = 3,
   parameter int LEFT_T    = 6
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       Ta,
   input  logic       Tb,
   input  logic       Tal,
   input  logic       Tbl,
   output logic [1:0] La,
   output logic [1:0] Lb,
   output logic [2:0] state,
   output logic       phase_change
);
   localparam logic [CNT_W-1:0] G_MIN = CNT_W'(GREEN_MIN - 1);
   localparam logic [CNT_W-1:0] G_MAX = CNT_W'(GREEN_MAX - 1);
   localparam logic [CNT_W-1:0] Y_END = CNT_W'(YELLOW_T - 1);
   localparam logic [CNT_W-1:0] L_END = CNT_W'(LEFT_T - 1);

   logic [CNT_W-1:0] cnt;
   logic [2:0]       next_state;
   logic             tal_pend, tbl_pend, a_go, b_go, change;

   assign change = next_state != state;

   tl_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (change),
      .cnt     (cnt)
   );

   // A green yields only to real demand, and keeps right of way while Ta holds until max.
   assign a_go = (Tb | tbl_pend | tal_pend) && cnt >= G_MIN && (!Ta || cnt >= G_MAX);
   assign b_go = (Ta | tal_pend | tbl_pend) && cnt >= G_MIN && (!Tb || cnt >= G_MAX);

   always_comb begin
      next_state = state;
      case (state)
         A_GRN:   next_state = a_go ? A_YEL : A_GRN;
         A_YEL:   next_state = (cnt == Y_END) ? (tal_pend ? A_LFT : B_GRN) : A_YEL;
         A_LFT:   next_state = (cnt == L_END) ? A_LYEL : A_LFT;
         A_LYEL:  next_state = (cnt == Y_END) ? B_GRN : A_LYEL;
         B_GRN:   next_state = b_go ? B_YEL : B_GRN;
         B_YEL:   next_state = (cnt == Y_END) ? (tbl_pend ? B_LFT : A_GRN) : B_YEL;
         B_LFT:   next_state = (cnt == L_END) ? B_LYEL : B_LFT;
         default: next_state = (cnt == Y_END) ? A_GRN : B_LYEL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state        <= A_GRN;
         tal_pend     <= 1'b0;
         tbl_pend     <= 1'b0;
         La           <= L_GREEN;
         Lb           <= L_RED;
         phase_change <= 1'b0;
      end else begin
         state        <= next_state;
         tal_pend     <= (next_state == A_LFT && state != A_LFT) ? 1'b0 :
                         (Tal && state != A_LFT && state != A_LYEL) ? 1'b1 : tal_pend;
         tbl_pend     <= (next_state == B_LFT && state != B_LFT) ? 1'b0 :
                         (Tbl && state != B_LFT && state != B_LYEL) ? 1'b1 : tbl_pend;
         {La, Lb}     <= lights(next_state);
         phase_change <= change;
      end
endmodule

// File: doc/tl_phase_scheduler.md
Name: tl_phase_scheduler

Overview:
Timed phase scheduler for a two-road intersection with protected left turns. It sequences eight light phases from the road sensors (Ta, Tb) and the left-turn requests (Tal, Tbl). It enforces minimum and maximum green times and fixed yellow and left durations, and latches left requests so that short pulses are not lost. It is the timing and arbitration layer above the structural next-state/output logic of the traffic-light controller. It drives La/Lb directly.

Parameters:
- CNT_W, 8, width of the phase cycle counter.
- GREEN_MIN, 10, minimum through-green length in cycles.
- GREEN_MAX, 40, green length after which the phase yields to pending demand.
- YELLOW_T, 3, length of every yellow phase in cycles.
- LEFT_T, 6, length of every protected-left phase in cycles.
- Constraints: 1 <= YELLOW_T, LEFT_T, GREEN_MIN <= GREEN_MAX <= 2**CNT_W.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- Ta  in  1  road A through-traffic present (level).
- Tb  in  1  road B through-traffic present (level).
- Tal  in  1  road A left-turn request (pulse or level).
- Tbl  in  1  road B left-turn request (pulse or level).
- La  out  2  road A light: 00 green, 01 yellow, 10 left arrow, 11 red.
- Lb  out  2  road B light, same encoding.
- state  out  3  current phase, for debug and bench observation.
- phase_change  out  1  one-cycle pulse in the first cycle of every new phase.

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (reset_n). All flops clear immediately on reset_n=0.
- Reset values:
  - state = A_GRN.
  - cnt = 0.
  - tal_pend = 0, tbl_pend = 0.
  - La = 00, Lb = 11.
  - phase_change = 0.
- Phase encodings:
  - A_GRN=0, A_YEL=1, A_LFT=2, A_LYEL=3.
  - B_GRN=4, B_YEL=5, B_LFT=6, B_LYEL=7.
- Outputs are Moore, decoded from the state register. La/Lb change in the same cycle as state.
- Light decode:
  - A_GRN: La=00, Lb=11.
  - A_YEL and A_LYEL: La=01, Lb=11.
  - A_LFT: La=10, Lb=11.
  - B phases mirror the A phases, with the roles of La and Lb swapped.
- Counter cnt:
  - Cleared to 0 on every phase transition.
  - Otherwise increments each cycle and saturates at 2**CNT_W-1.
- Green exit condition from A_GRN → A_YEL:
  - Requires demand = Tb | tbl_pend | tal_pend.
  - Also requires cnt >= GREEN_MIN-1.
  - Also requires either !Ta or cnt >= GREEN_MAX-1.
  - With no demand, A_GRN is held indefinitely.
  - Resulting green length: GREEN_MIN..GREEN_MAX cycles when demand exists.
- A_YEL exits at cnt == YELLOW_T-1:
  - to A_LFT if tal_pend = 1;
  - otherwise to B_GRN.
- A_LFT exits at cnt == LEFT_T-1 → A_LYEL.
- A_LYEL exits at cnt == YELLOW_T-1 → B_GRN.
- B side is symmetric: Ta↔Tb, tal_pend↔tbl_pend, and B_LYEL/B_YEL return to A_GRN.
- Left-request latches:
  - tal_pend is set by Tal=1 in any cycle whose state is not A_LFT or A_LYEL.
  - tal_pend is cleared on the cycle that enters A_LFT.
  - Clear has priority over set.
  - A request arriving in A_YEL's final cycle is still honoured in that same transition only if it is already latched. Otherwise it waits for the next A cycle.
  - tbl_pend follows the same rules.
- phase_change = registered (next_state != state). It is high for exactly the first cycle of each new phase and 0 during reset.
- Inputs are assumed synchronous to clk. No internal synchronisers.
- Reset mid-phase: the controller returns to A_GRN with latches cleared. No yellow is inserted.

Decomposition:
- Shared package tl_pkg:
  - phase state localparams (A_GRN..B_LYEL);
  - light codes (L_GREEN, L_YELLOW, L_LEFT, L_RED).
- Sub-module tl_phase_timer:
  - CNT_W counter with synchronous clear, saturation and async reset_n;
  - outputs cnt.
- The top level holds:
  - the 3-bit state register (reuses _register3_r);
  - next-state logic;
  - the pending latches;
  - output decode.

Test Plan:
- Reset, then Ta=1, Tb=0, no left requests, for 200 cycles → state stays 0, La=00, Lb=11, phase_change never 1.
- Ta=0, Tb=1 from reset release → A_GRN for 10 cycles, A_YEL for 3, B_GRN entered at cycle 13, phase_change pulses at cycles 10 and 13.
- Ta=1, Tb=1 held → A_GRN lasts exactly 40 cycles (GREEN_MAX), then 3 yellow, then B_GRN for 40 cycles, then B_YEL, then A_GRN; the cycle repeats.
- Ta=0, Tb=1, plus a one-cycle Tal pulse at cycle 2 → A_GRN 10, A_YEL 3, A_LFT 6 (La=10), A_LYEL 3, then B_GRN at cycle 22; tal_pend=0 after A_LFT entry.
- Tbl held high throughout a B_LFT phase → no second B_LFT is queued; the next B cycle goes B_YEL→A_GRN unless Tbl is re-asserted outside B_LFT/B_LYEL.
- reset_n pulsed low mid-A_LFT (async, between edges) → La=00, Lb=11, state=0, pend=0 immediately; normal timing resumes from cnt=0.
